// File: rtl/ervp_apb_user_reg_bank_pkg.sv
// Shared encodings and helpers for the APB user register bank.
package ervp_apb_user_reg_bank_pkg;

  // Per-slot operating mode, two bits per slot in the flat REG_MODE vector
  localparam logic [1:0] REG_MODE_EXT = 2'd0;
  localparam logic [1:0] REG_MODE_RW  = 2'd1;
  localparam logic [1:0] REG_MODE_RO  = 2'd2;
  localparam logic [1:0] REG_MODE_W1C = 2'd3;

  // Bus byte order selection
  localparam int LITTLE_ENDIAN = 0;
  localparam int BIG_ENDIAN    = 1;

  // Width of the EXT wait-state counter (WAIT_TIMEOUT tops out at 65535)
  localparam int BW_WAIT_CNT = 16;

  // Transfer FSM: IDLE accepts new accesses, WAIT holds an EXT transfer open
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Slot index width; a single-slot bank still needs a one-bit index
  function automatic int reg_index_width(input int num_reg);
    return (num_reg > 1) ? $clog2(num_reg) : 1;
  endfunction

  // Reverse the four bytes of a 32-bit word
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/ervp_apb_user_reg_cell.sv
// One internal register slot: RW storage, RO pass-through or W1C status bits.
// EXT slots instantiate this cell too; its outputs are then tied to zero.
module ervp_apb_user_reg_cell
  import ervp_apb_user_reg_bank_pkg::*;
#(
  parameter logic [1:0]  MODE        = REG_MODE_RW,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstnn,
  input  logic        wr_en_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] set_i,
  input  logic [31:0] ext_rdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] value_o
);

  logic [31:0] value_q;
  logic [31:0] value_d;

  // Next contents: RW takes the write, W1C clears written ones then applies set (set wins)
  always_comb begin
    value_d = value_q;
    case (MODE)
      REG_MODE_RW: begin
        if (wr_en_i) value_d = wdata_i;
        else         value_d = value_q;
      end
      REG_MODE_W1C: begin
        value_d = (value_q & ~(wr_en_i ? wdata_i : 32'h0000_0000)) | set_i;
      end
      default: value_d = value_q;
    endcase
  end

  // Storage register, loaded with the slot reset value
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) value_q <= RESET_VALUE;
    else        value_q <= value_d;
  end

  // Read data and exported contents per mode
  always_comb begin
    rdata_o = 32'h0000_0000;
    value_o = 32'h0000_0000;
    case (MODE)
      REG_MODE_RW, REG_MODE_W1C: begin
        rdata_o = value_q;
        value_o = value_q;
      end
      REG_MODE_RO: begin
        rdata_o = ext_rdata_i;
        value_o = 32'h0000_0000;
      end
      default: begin
        rdata_o = 32'h0000_0000;
        value_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/ervp_apb_user_reg_bank.sv
// APB slave exposing NUM_REG user register slots. Internal slots answer with
// zero wait states; EXT slots hand the access to user logic through a
// one-cycle request and wait for user_ready, bounded by WAIT_TIMEOUT.
module ervp_apb_user_reg_bank
  import ervp_apb_user_reg_bank_pkg::*;
#(
  parameter int                    NUM_REG         = 16,
  parameter int                    BW_ADDR         = 12,
  parameter int                    BASE_OFFSET     = 0,
  parameter logic [2*NUM_REG-1:0]  REG_MODE        = '0,
  parameter logic [32*NUM_REG-1:0] REG_RESET_VALUE = '0,
  parameter int                    WAIT_TIMEOUT    = 255,
  parameter int                    ENDIAN          = LITTLE_ENDIAN
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    rpsel,
  input  logic                    rpenable,
  input  logic [BW_ADDR-1:0]      rpaddr,
  input  logic                    rpwrite,
  input  logic [31:0]             rpwdata,
  output logic [31:0]             rprdata,
  output logic                    rpready,
  output logic                    rpslverr,
  output logic [NUM_REG-1:0]      user_rreq,
  output logic [NUM_REG-1:0]      user_wreq,
  output logic [32*NUM_REG-1:0]   user_wdata,
  input  logic [32*NUM_REG-1:0]   user_rdata,
  input  logic [NUM_REG-1:0]      user_ready,
  output logic [32*NUM_REG-1:0]   reg_value,
  input  logic [32*NUM_REG-1:0]   status_set,
  output logic                    irq
);

  localparam int BW_REG_INDEX = reg_index_width(NUM_REG);
  localparam logic [BW_WAIT_CNT-1:0] TIMEOUT_LAST = BW_WAIT_CNT'(WAIT_TIMEOUT - 1);

  // irq comes out of reset as the OR of all W1C reset values
  function automatic logic irq_reset_calc();
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REG; i++) begin
      if ((REG_MODE[2*i +: 2] == REG_MODE_W1C) && (REG_RESET_VALUE[32*i +: 32] != 32'h0000_0000))
        r = 1'b1;
    end
    return r;
  endfunction
  localparam logic IRQ_RESET = irq_reset_calc();

  // Apply the bus byte order to a data word (symmetric for both directions)
  function automatic logic [31:0] bus_order(input logic [31:0] d);
    return (ENDIAN == BIG_ENDIAN) ? byte_swap(d) : d;
  endfunction

  state_e                  state_q, state_d;
  logic [BW_WAIT_CNT-1:0]  cnt_q, cnt_d;
  logic [BW_REG_INDEX-1:0] idx_q, idx_d;
  logic                    write_q, write_d;
  logic                    irq_q;

  logic                    access_s;
  logic [31:0]             addr_ext_s;
  logic [31:0]             offset_s;
  logic [31:0]             slot_full_s;
  logic                    dec_err_s;
  logic [BW_REG_INDEX-1:0] idx_s;
  logic [1:0]              mode_s;
  logic [31:0]             wdata_bus_s;

  logic [1:0]              slot_mode_a  [NUM_REG];
  logic [31:0]             user_rdata_a [NUM_REG];
  logic [31:0]             cell_rdata_a [NUM_REG];
  logic [31:0]             cell_value_a [NUM_REG];
  logic [NUM_REG-1:0]      w1c_hit_s;
  logic [NUM_REG-1:0]      wr_en_s;
  logic [NUM_REG-1:0]      rreq_s;
  logic [NUM_REG-1:0]      wreq_s;
  logic                    resp_ready_s;
  logic                    resp_err_s;
  logic [31:0]             resp_rdata_s;

  // Address decode; BASE_OFFSET is 4-aligned so offset alignment equals address alignment
  assign access_s    = rpsel & rpenable & rstnn;
  assign addr_ext_s  = 32'(rpaddr);
  assign offset_s    = addr_ext_s - 32'(BASE_OFFSET);
  assign slot_full_s = {2'b00, offset_s[31:2]};
  assign dec_err_s   = (offset_s[1:0] != 2'b00) ||
                       (addr_ext_s < 32'(BASE_OFFSET)) ||
                       (slot_full_s >= 32'(NUM_REG));
  assign idx_s       = slot_full_s[BW_REG_INDEX-1:0];
  assign mode_s      = slot_mode_a[idx_s];
  assign wdata_bus_s = bus_order(rpwdata);

  for (genvar i = 0; i < NUM_REG; i++) begin : g_slot
    localparam logic [1:0] SLOT_MODE = REG_MODE[2*i +: 2];

    assign slot_mode_a[i]          = SLOT_MODE;
    assign user_rdata_a[i]         = user_rdata[32*i +: 32];
    assign user_wdata[32*i +: 32]  = wdata_bus_s;
    assign reg_value[32*i +: 32]   = cell_value_a[i];

    ervp_apb_user_reg_cell #(
      .MODE        (SLOT_MODE),
      .RESET_VALUE (REG_RESET_VALUE[32*i +: 32])
    ) u_cell (
      .clk         (clk),
      .rstnn       (rstnn),
      .wr_en_i     (wr_en_s[i]),
      .wdata_i     (wdata_bus_s),
      .set_i       (status_set[32*i +: 32]),
      .ext_rdata_i (user_rdata_a[i]),
      .rdata_o     (cell_rdata_a[i]),
      .value_o     (cell_value_a[i])
    );

    if (SLOT_MODE == REG_MODE_W1C) begin : g_w1c
      assign w1c_hit_s[i] = |cell_value_a[i];
    end else begin : g_no_w1c
      assign w1c_hit_s[i] = 1'b0;
    end
  end

  // Transfer control: decode, EXT request/wait/timeout, response generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    write_d      = write_q;
    rreq_s       = '0;
    wreq_s       = '0;
    wr_en_s      = '0;
    resp_ready_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          if (dec_err_s) begin
            resp_ready_s = 1'b1;
            resp_err_s   = 1'b1;
          end else if (mode_s == REG_MODE_EXT) begin
            idx_d   = idx_s;
            write_d = rpwrite;
            if (rpwrite) wreq_s[idx_s] = 1'b1;
            else         rreq_s[idx_s] = 1'b1;
            if (user_ready[idx_s]) begin
              resp_ready_s = 1'b1;
              resp_rdata_s = rpwrite ? 32'h0000_0000 : user_rdata_a[idx_s];
            end else begin
              state_d = ST_WAIT;
              cnt_d   = '0;
            end
          end else begin
            resp_ready_s = 1'b1;
            if (rpwrite) begin
              if (mode_s == REG_MODE_RO) resp_err_s     = 1'b1;
              else                       wr_en_s[idx_s] = 1'b1;
            end else begin
              resp_rdata_s = cell_rdata_a[idx_s];
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (!rpsel) begin
          // Master dropped the transfer: abort silently, late ready is ignored
          state_d = ST_IDLE;
        end else if (user_ready[idx_q]) begin
          // Ready has priority over a timeout in the same cycle
          resp_ready_s = access_s;
          resp_rdata_s = (access_s && !write_q) ? user_rdata_a[idx_q] : 32'h0000_0000;
          state_d      = ST_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          resp_ready_s = access_s;
          resp_err_s   = access_s;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, wait counter and captured request attributes
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  // Interrupt: registered OR of every W1C status bit
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) irq_q <= IRQ_RESET;
    else        irq_q <= |w1c_hit_s;
  end

  assign rpready   = resp_ready_s;
  assign rpslverr  = resp_err_s;
  assign rprdata   = resp_ready_s ? bus_order(resp_rdata_s) : 32'h0000_0000;
  assign user_rreq = rreq_s;
  assign user_wreq = wreq_s;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ervp_apb_user_reg_bank.sv
// Directed + randomized bench for ervp_apb_user_reg_bank (16 slots, timeout 8).
module tb_ervp_apb_user_reg_bank;

  localparam int N = 16;

  // Slot map used by this bench: 0,1 EXT; 5 W1C; 6 RO; everything else RW
  function automatic logic [1:0] slot_mode(input int i);
    case (i)
      0, 1:    return 2'd0;
      5:       return 2'd3;
      6:       return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [31:0] reset_of(input int i);
    case (i)
      3:       return 32'h0000_00A5;
      7:       return 32'h7777_0007;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [2*N-1:0] mk_modes();
    logic [2*N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[2*i +: 2] = slot_mode(i);
    return m;
  endfunction

  function automatic logic [32*N-1:0] mk_resets();
    logic [32*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[32*i +: 32] = reset_of(i);
    return r;
  endfunction

  localparam logic [2*N-1:0]  MODES  = mk_modes();
  localparam logic [32*N-1:0] RESETS = mk_resets();

  logic            clk = 1'b0;
  logic            rstnn = 1'b0;
  logic            rpsel = 1'b0;
  logic            rpenable = 1'b0;
  logic [11:0]     rpaddr = 12'h000;
  logic            rpwrite = 1'b0;
  logic [31:0]     rpwdata = 32'h0;
  logic [31:0]     rprdata;
  logic            rpready;
  logic            rpslverr;
  logic [N-1:0]    user_rreq;
  logic [N-1:0]    user_wreq;
  logic [32*N-1:0] user_wdata;
  logic [32*N-1:0] user_rdata = '0;
  logic [N-1:0]    user_ready;
  logic [32*N-1:0] reg_value;
  logic [32*N-1:0] status_set = '0;
  logic            irq;

  ervp_apb_user_reg_bank #(
    .NUM_REG(N), .BW_ADDR(12), .BASE_OFFSET(0), .REG_MODE(MODES),
    .REG_RESET_VALUE(RESETS), .WAIT_TIMEOUT(8), .ENDIAN(0)
  ) dut (
    .clk(clk), .rstnn(rstnn), .rpsel(rpsel), .rpenable(rpenable), .rpaddr(rpaddr),
    .rpwrite(rpwrite), .rpwdata(rpwdata), .rprdata(rprdata), .rpready(rpready),
    .rpslverr(rpslverr), .user_rreq(user_rreq), .user_wreq(user_wreq),
    .user_wdata(user_wdata), .user_rdata(user_rdata), .user_ready(user_ready),
    .reg_value(reg_value), .status_set(status_set), .irq(irq)
  );

  always #5 clk = ~clk;

  // Slot 0 responder: user_ready[0] high for one cycle, 4 cycles after user_rreq[0]
  logic       resp_en = 1'b1;
  logic [3:0] rsp_cnt = 4'd0;
  logic       rdy0 = 1'b0;
  always @(posedge clk) begin
    rdy0 <= 1'b0;
    if (user_rreq[0] && resp_en) begin
      rsp_cnt <= 4'd3;
    end else if (rsp_cnt != 4'd0) begin
      rsp_cnt <= rsp_cnt - 4'd1;
      if (rsp_cnt == 4'd1) rdy0 <= 1'b1;
    end
  end
  assign user_ready = {{(N-1){1'b0}}, rdy0};

  // Count request pulses (cycles each line is high)
  int rreq_tot = 0;
  int wreq_tot = 0;
  always @(negedge clk) begin
    rreq_tot += $countones(user_rreq);
    wreq_tot += $countones(user_wreq);
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_value(input int i);
    return (slot_mode(i) == 2'd1 || slot_mode(i) == 2'd3) ? mdl[i] : 32'h0;
  endfunction

  task automatic chk_all_regs(input string tag);
    for (int i = 0; i < N; i++) chk(tag, reg_value[32*i +: 32], exp_value(i));
  endtask

  // One APB transfer; waits = access-phase cycles sampled without rpready
  task automatic apb(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int waits);
    logic done;
    done = 1'b0; rd = 32'h0; err = 1'b0; waits = 0;
    @(posedge clk); #1;
    rpsel = 1'b1; rpenable = 1'b0; rpaddr = addr; rpwrite = wr; rpwdata = wd;
    @(posedge clk); #1;
    rpenable = 1'b1;
    while (!done && waits < 100) begin
      @(negedge clk);
      if (rpready) begin
        done = 1'b1; rd = rprdata; err = rpslverr;
      end else begin
        waits++;
      end
    end
    chk("apb_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    rpsel = 1'b0; rpenable = 1'b0;
  endtask

  logic [31:0] rd, wd, exp_rd;
  logic        err, exp_err, wr;
  int          waits, r0, w0, s;

  initial begin
    for (int i = 0; i < N; i++) begin
      user_rdata[32*i +: 32] = 32'hC0DE_0000 | 32'(i);
      mdl[i] = reset_of(i);
    end
    user_rdata[0 +: 32]    = 32'h1234_5678;
    user_rdata[32*6 +: 32] = 32'h6666_0006;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rpready", 32'(rpready), 32'd0);
    chk("rst_rpslverr", 32'(rpslverr), 32'd0);
    chk("rst_rprdata", rprdata, 32'h0);
    chk("rst_rreq", 32'(user_rreq), 32'd0);
    chk("rst_wreq", 32'(user_wreq), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk_all_regs("rst_regs");
    @(posedge clk); #1;
    rstnn = 1'b1;

    // RW slot 3
    apb(12'h00C, 1'b0, 32'h0, rd, err, waits);
    chk("rw3_rd_reset", rd, 32'h0000_00A5);
    chk("rw3_waits", 32'(waits), 32'd0);
    apb(12'h00C, 1'b1, 32'hDEAD_BEEF, rd, err, waits);
    mdl[3] = 32'hDEAD_BEEF;
    chk("rw3_wr_err", 32'(err), 32'd0);
    apb(12'h00C, 1'b0, 32'h0, rd, err, waits);
    chk("rw3_rd_new", rd, 32'hDEAD_BEEF);
    chk("rw3_regval", reg_value[32*3 +: 32], 32'hDEAD_BEEF);

    // EXT slot 0 read with 4 wait cycles
    r0 = rreq_tot; w0 = wreq_tot;
    apb(12'h000, 1'b0, 32'h0, rd, err, waits);
    chk("ext0_rd", rd, 32'h1234_5678);
    chk("ext0_err", 32'(err), 32'd0);
    chk("ext0_waits", 32'(waits), 32'd4);
    chk("ext0_rreq_once", 32'(rreq_tot - r0), 32'd1);
    chk("ext0_no_wreq", 32'(wreq_tot - w0), 32'd0);

    // EXT slot 1 write, never ready: timeout after 8 wait cycles
    r0 = rreq_tot; w0 = wreq_tot;
    apb(12'h004, 1'b1, 32'hA1B2_C3D4, rd, err, waits);
    chk("ext1_err", 32'(err), 32'd1);
    chk("ext1_rd", rd, 32'h0);
    chk("ext1_waits", 32'(waits), 32'd8);
    chk("ext1_wreq_once", 32'(wreq_tot - w0), 32'd1);
    chk("ext1_no_rreq", 32'(rreq_tot - r0), 32'd0);
    chk("ext1_wdata", user_wdata[32*1 +: 32], 32'hA1B2_C3D4);

    // W1C slot 5
    @(posedge clk); #1;
    status_set[32*5 + 2] = 1'b1;
    @(posedge clk); #1;
    status_set[32*5 + 2] = 1'b0;
    mdl[5] = mdl[5] | 32'h4;
    @(posedge clk);
    @(negedge clk);
    chk("w1c_irq_set", 32'(irq), 32'd1);
    chk("w1c_val_set", reg_value[32*5 +: 32], 32'h4);
    status_set[32*5 + 2] = 1'b1;
    apb(12'h014, 1'b1, 32'h4, rd, err, waits);
    status_set[32*5 + 2] = 1'b0;
    apb(12'h014, 1'b0, 32'h0, rd, err, waits);
    chk("w1c_set_wins", rd, 32'h4);
    apb(12'h014, 1'b1, 32'h4, rd, err, waits);
    mdl[5] = 32'h0;
    apb(12'h014, 1'b0, 32'h0, rd, err, waits);
    chk("w1c_cleared", rd, 32'h0);
    @(negedge clk);
    chk("w1c_irq_clr", 32'(irq), 32'd0);

    // Error responses
    r0 = rreq_tot; w0 = wreq_tot;
    apb(12'h002, 1'b0, 32'h0, rd, err, waits);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_rd", rd, 32'h0);
    chk("mis_waits", 32'(waits), 32'd0);
    apb(12'h040, 1'b0, 32'h0, rd, err, waits);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_rd", rd, 32'h0);
    apb(12'h018, 1'b1, 32'hFFFF_FFFF, rd, err, waits);
    chk("ro_wr_err", 32'(err), 32'd1);
    chk("err_no_rreq", 32'(rreq_tot - r0), 32'd0);
    chk("err_no_wreq", 32'(wreq_tot - w0), 32'd0);
    chk_all_regs("err_regs");
    apb(12'h018, 1'b0, 32'h0, rd, err, waits);
    chk("ro_rd", rd, 32'h6666_0006);
    chk("ro_rd_err", 32'(err), 32'd0);

    // Randomized internal accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      s  = $urandom_range(2, N-1);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_err = 1'b0;
      exp_rd  = 32'h0;
      case (slot_mode(s))
        2'd1:    if (wr) mdl[s] = wd; else exp_rd = mdl[s];
        2'd3:    if (wr) mdl[s] = mdl[s] & ~wd; else exp_rd = mdl[s];
        default: if (wr) exp_err = 1'b1; else exp_rd = user_rdata[32*s +: 32];
      endcase
      apb(12'(4*s), wr, wd, rd, err, waits);
      chk("rnd_err", 32'(err), 32'(exp_err));
      chk("rnd_waits", 32'(waits), 32'd0);
      if (!wr) chk("rnd_rd", rd, exp_rd);
      chk("rnd_regval", reg_value[32*s +: 32], exp_value(s));
    end

    // Reset in the middle of an EXT wait
    apb(12'h00C, 1'b1, 32'h0BAD_F00D, rd, err, waits);
    mdl[3] = 32'h0BAD_F00D;
    resp_en = 1'b0;
    @(posedge clk); #1;
    rpsel = 1'b1; rpenable = 1'b0; rpaddr = 12'h000; rpwrite = 1'b0;
    @(posedge clk); #1;
    rpenable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstnn = 1'b0; rpsel = 1'b0; rpenable = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = reset_of(i);
    @(negedge clk);
    chk("mid_rst_rpready", 32'(rpready), 32'd0);
    chk("mid_rst_rreq", 32'(user_rreq), 32'd0);
    chk_all_regs("mid_rst_regs");
    @(posedge clk); #1;
    rstnn = 1'b1;
    resp_en = 1'b1;
    apb(12'h00C, 1'b0, 32'h0, rd, err, waits);
    chk("post_rst_rd", rd, 32'h0000_00A5);
    chk("post_rst_waits", 32'(waits), 32'd0);
    apb(12'h000, 1'b0, 32'h0, rd, err, waits);
    chk("post_rst_ext", rd, 32'h1234_5678);
    chk("post_rst_ext_waits", 32'(waits), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
